// File: rtl/axil_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : axil_pkg                                                          |
// | Brief  : Shared types and constants for the AXI4-Lite initiator.           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

endpackage
`default_nettype wire

// File: rtl/axil_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : axil_master                                                       |
// | Brief  : Single-outstanding AXI4-Lite initiator driven by a command stream |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module axil_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_areset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,

    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,

    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    input  logic [1:0]            m_axi_bresp,

    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,

    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp
);

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_rsp_valid;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    resp_t                 r_rsp_resp;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_fin;
    logic w_w_fin;

    // A channel counts as finished if it completed earlier or completes on this edge
    assign w_aw_hs  = r_awvalid & m_axi_awready;
    assign w_w_hs   = r_wvalid & m_axi_wready;
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done | w_w_hs;

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= OKAY;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_wstrb     <= cmd_wstrb;
                        if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= ST_WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RADDR;
                        end
                    end
                end
                ST_WR: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (m_axi_bvalid && r_bready) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= resp_t'(m_axi_bresp);
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RADDR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (m_axi_rvalid && r_rready) begin
                        r_rready    <= 1'b0;
                        r_rsp_resp  <= resp_t'(m_axi_rresp);
                        r_rsp_rdata <= m_axi_rdata;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;

    assign m_axi_awvalid = r_awvalid;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awprot  = AXIL_PROT_DEFAULT;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_bready  = r_bready;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arprot  = AXIL_PROT_DEFAULT;
    assign m_axi_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axil_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_axil_master                                                    |
// | Brief  : Randomised bench for axil_master with a stalling register slave.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_axil_master;
    import axil_pkg::*;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        awvalid, awready = 1'b0;
    logic [15:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid, wready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid = 1'b0, bready;
    logic [1:0]  bresp = 2'd0;
    logic        arvalid, arready = 1'b0;
    logic [15:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid = 1'b0, rready;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'd0;

    always #5 clk = ~clk;

    axil_master #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) u_dut (
        .m_axi_aclk(clk), .m_axi_areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Slave BFM: 16 x 32-bit registers at 0x00-0x3C, SLVERR page at 0xEExx, DECERR elsewhere
    logic [31:0] sl_mem [16];
    bit          aw_have, w_have, ar_have, b_done, r_done, rst_seen;
    logic [15:0] aw_a, ar_a;
    logic [31:0] w_d;
    logic [3:0]  w_s;
    int          stall_pct = 0;
    int          aw_stall  = 0;
    logic        p_awvalid = 1'b0, p_awready = 1'b0, p_wvalid = 1'b0, p_wready = 1'b0;
    logic        p_arvalid = 1'b0, p_arready = 1'b0;
    logic [15:0] p_awaddr, p_araddr;
    logic [31:0] p_wdata;
    logic [3:0]  p_wstrb;

    function automatic bit go();
        return $urandom_range(99) >= stall_pct;
    endfunction

    function automatic logic [1:0] sl_resp(input logic [15:0] a);
        if (a[15:8] == 8'hEE) return SLVERR;
        if (a >= 16'h0040)    return DECERR;
        return OKAY;
    endfunction

    // Handshakes are sampled from pre-edge values at the rising edge
    initial forever begin
        @(posedge clk);
        if (areset) begin
            aw_have = 0; w_have = 0; ar_have = 0; b_done = 0; r_done = 0; rst_seen = 1;
            for (int i = 0; i < 16; i++) sl_mem[i] = '0;
        end else begin
            if (awvalid && awready) begin aw_have = 1; aw_a = awaddr; end
            if (wvalid && wready)   begin w_have = 1; w_d = wdata; w_s = wstrb; end
            if (bvalid && bready)   b_done = 1;
            if (arvalid && arready) begin ar_have = 1; ar_a = araddr; end
            if (rvalid && rready)   r_done = 1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_seen) begin
            rst_seen = 0;
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            p_awvalid = 0; p_wvalid = 0; p_arvalid = 0;
            continue;
        end
        if (p_awvalid && !p_awready) begin
            check("aw_valid_hold", awvalid, 1);
            check("aw_addr_stable", awaddr, p_awaddr);
        end
        if (p_wvalid && !p_wready) begin
            check("w_valid_hold", wvalid, 1);
            check("w_data_stable", wdata, p_wdata);
            check("w_strb_stable", wstrb, p_wstrb);
        end
        if (p_arvalid && !p_arready) begin
            check("ar_valid_hold", arvalid, 1);
            check("ar_addr_stable", araddr, p_araddr);
        end
        if (awvalid) check("awprot", awprot, 0);
        if (arvalid) check("arprot", arprot, 0);
        if (b_done) begin bvalid = 0; b_done = 0; end
        if (r_done) begin rvalid = 0; r_done = 0; end
        if (aw_stall > 0 && awvalid) begin
            awready = 0;
            aw_stall--;
        end else begin
            awready = !aw_have && go();
        end
        wready  = !w_have && go();
        arready = !ar_have && go();
        if (aw_have && w_have && !bvalid && go()) begin
            bresp = sl_resp(aw_a);
            if (bresp == OKAY)
                for (int b = 0; b < 4; b++)
                    if (w_s[b]) sl_mem[aw_a[5:2]][8*b +: 8] = w_d[8*b +: 8];
            bvalid = 1; aw_have = 0; w_have = 0;
        end
        if (ar_have && !rvalid && go()) begin
            rresp = sl_resp(ar_a);
            rdata = (rresp == SLVERR) ? 32'h12345678 : (rresp == DECERR) ? 32'h0 : sl_mem[ar_a[5:2]];
            rvalid = 1; ar_have = 0;
        end
        p_awvalid = awvalid; p_awready = awready; p_awaddr = awaddr;
        p_wvalid = wvalid; p_wready = wready; p_wdata = wdata; p_wstrb = wstrb;
        p_arvalid = arvalid; p_arready = arready; p_araddr = araddr;
    end

    // Reference model: what a register file behind this address map should return
    logic [31:0] ref_mem [16];

    task automatic model(input bit wr, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] exp_d, output logic [1:0] exp_r);
        exp_d = 32'h0;
        if (a[15:8] == 8'hEE) begin
            exp_r = 2'd2;
            if (!wr) exp_d = 32'h12345678;
        end else if (a >= 16'h0040) begin
            exp_r = 2'd3;
        end else begin
            exp_r = 2'd0;
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[a / 4][8*b +: 8] = d[8*b +: 8];
            end else begin
                exp_d = ref_mem[a / 4];
            end
        end
    endtask

    // Offers a command; returns one negedge after the accepting edge (cycle 1)
    task automatic issue(input bit wr, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
        if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
        @(negedge clk);
        cmd_valid = 0;
        cmd_write = $urandom_range(1); cmd_addr = 16'($urandom); cmd_wdata = $urandom;
    endtask

    task automatic finish(input string tag, input logic [31:0] exp_d, input logic [1:0] exp_r,
                          input int hold, output int lat, output logic [31:0] act_d);
        logic [31:0] d0;
        logic [1:0]  r0;
        int k = 1;
        while (!rsp_valid && k < 300) begin @(negedge clk); k++; end
        lat = k; act_d = rsp_rdata;
        if (!rsp_valid) begin
            check({tag, "_rsp_timeout"}, 0, 1);
            return;
        end
        d0 = rsp_rdata; r0 = rsp_resp;
        check({tag, "_rdata"}, rsp_rdata, exp_d);
        check({tag, "_resp"}, rsp_resp, exp_r);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 0;
            @(negedge clk);
            check({tag, "_hold_valid"}, rsp_valid, 1);
            check({tag, "_hold_rdata"}, rsp_rdata, d0);
            check({tag, "_hold_resp"}, rsp_resp, r0);
            check({tag, "_hold_cmd_ready"}, cmd_ready, 0);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check({tag, "_rsp_drop"}, rsp_valid, 0);
        check({tag, "_cmd_ready_back"}, cmd_ready, 1);
    endtask

    task automatic run(input string tag, input bit wr, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int hold, output int lat, output logic [31:0] act_d);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        model(wr, a, d, s, exp_d, exp_r);
        issue(wr, a, d, s);
        finish(tag, exp_d, exp_r, hold, lat, act_d);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] got, exp_d;
        logic [1:0]  exp_r;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_rready", rready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_resp", rsp_resp, 0);
        areset = 0;
        @(negedge clk);

        // Zero-wait write then read-back with latency
        stall_pct = 0;
        run("t1_wr", 1, 16'h0004, 32'hDEADBEEF, 4'hF, 0, lat, got);
        check("t1_wr_lat", lat, 3);
        run("t1_rd", 0, 16'h0004, 32'h0, 4'h0, 0, lat, got);
        check("t1_rd_lat", lat, 3);
        check("t1_rd_value", got, 32'hDEADBEEF);

        // Partial strobes merge into existing data
        run("t2_wr0", 1, 16'h0008, 32'h11223344, 4'hF, 0, lat, got);
        run("t2_wr1", 1, 16'h0008, 32'hAABBCCDD, 4'h5, 0, lat, got);
        run("t2_rd", 0, 16'h0008, 32'h0, 4'h0, 0, lat, got);
        check("t2_rd_value", got, 32'h11BB33DD);

        // AW stalled 5 cycles while W completes immediately
        aw_stall = 5;
        model(1, 16'h000C, 32'hCAFEF00D, 4'hF, exp_d, exp_r);
        issue(1, 16'h000C, 32'hCAFEF00D, 4'hF);
        check("t3_c1_awvalid", awvalid, 1);
        check("t3_c1_wvalid", wvalid, 1);
        @(negedge clk);
        check("t3_c2_wvalid", wvalid, 0);
        check("t3_c2_awvalid", awvalid, 1);
        check("t3_c2_bready", bready, 0);
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            check("t3_awvalid_held", awvalid, 1);
            check("t3_awaddr", awaddr, 16'h000C);
            check("t3_bready_low", bready, 0);
        end
        finish("t3_wr", exp_d, exp_r, 0, lat, got);
        run("t3_rd", 0, 16'h000C, 32'h0, 4'h0, 0, lat, got);
        check("t3_rd_value", got, 32'hCAFEF00D);

        // Error responses pass through; response held while rsp_ready low
        run("t4_rd_slverr", 0, 16'hEE10, 32'h0, 4'h0, 4, lat, got);
        check("t4_rd_value", got, 32'h12345678);
        run("t4_wr_slverr", 1, 16'hEE10, 32'h55555555, 4'hF, 2, lat, got);
        run("t4_rd_decerr", 0, 16'h0100, 32'h0, 4'h0, 1, lat, got);

        // Reset while the write waits on awready
        aw_stall = 20;
        issue(1, 16'h0010, 32'h01020304, 4'hF);
        @(negedge clk);
        areset = 1;
        @(negedge clk);
        areset = 0;
        aw_stall = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        check("t5_awvalid", awvalid, 0);
        check("t5_wvalid", wvalid, 0);
        check("t5_arvalid", arvalid, 0);
        check("t5_bready", bready, 0);
        check("t5_rsp_valid", rsp_valid, 0);
        check("t5_cmd_ready", cmd_ready, 1);
        run("t5_rd", 0, 16'h0000, 32'h0, 4'h0, 0, lat, got);
        check("t5_rd_lat", lat, 3);

        // Random traffic with stalls on every channel
        stall_pct = 30;
        for (int t = 0; t < 1000; t++) begin
            int          sel;
            bit          wr;
            logic [15:0] a;
            sel = $urandom_range(99);
            wr  = 1'($urandom_range(1));
            if (sel < 80)      a = 16'({$urandom_range(15), 2'b00});
            else if (sel < 90) a = 16'h0040 + 16'($urandom_range(16'h0FFF));
            else               a = 16'hEE00 | 16'($urandom_range(255));
            run("rnd", wr, a, $urandom, 4'($urandom_range(15)), $urandom_range(3), lat, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
